// File: rtl/video_pkg.sv
// Shared video-path definitions: pixel and DRAM word widths, 720p frame size,
// and the write-packer state encoding.
package video_pkg;
    localparam int PIXEL_W           = 16;
    localparam int DRAM_WORD_W       = 128;
    localparam int FRAME_PIXELS_720P = 921600;

    typedef enum logic [1:0] {PK_RUN, PK_DISCARD, PK_FLUSH} packer_state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO on registered storage. The head word is visible
// on pop_data whenever the FIFO is non-empty; pop_data reads zero when empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 64
) (
    input  logic                     clk_pixel,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_pixel) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/reverb_dram_write_packer.sv
// Packs the 16-bit reverb frame-store stream into 128-bit DRAM words with tlast,
// and keeps DRAM addressing frame-aligned across overflow and malformed frames.
//
// state      | meaning
// PK_RUN     | packing pixels into words and pushing them to the FIFO
// PK_DISCARD | a word was lost; drop pixels until the frame's s_last
// PK_FLUSH   | push a zero word with tlast to close the truncated frame
module reverb_dram_write_packer
    import video_pkg::*;
#(
    parameter int PACK_FACTOR  = 8,
    parameter int FIFO_DEPTH   = 64,
    parameter int FRAME_PIXELS = FRAME_PIXELS_720P
) (
    input  logic                   clk_pixel,
    input  logic                   rst,
    input  logic [PIXEL_W-1:0]     s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic [DRAM_WORD_W-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   frame_error,
    output logic                   overflow,
    output logic [7:0]             frames_dropped
);
    localparam int LANE_W = $clog2(PACK_FACTOR);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_FACTOR - 1);

    packer_state_t          state;
    logic [LANE_W-1:0]      lane;
    logic [DRAM_WORD_W-1:0] pack_reg;
    logic [DRAM_WORD_W-1:0] word_next;
    logic [19:0]            pix_cnt;

    logic                   push_req;
    logic                   push_room;
    logic                   push;
    logic [DRAM_WORD_W-1:0] push_word;
    logic                   push_last;
    logic                   pop;
    logic [DRAM_WORD_W:0]   fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count_unused;

    always_comb begin
        word_next = pack_reg;
        word_next[int'(lane)*PIXEL_W +: PIXEL_W] = s_data;
    end

    always_comb begin
        push_req  = 1'b0;
        push_word = '0;
        push_last = 1'b0;
        unique case (state)
            PK_RUN: begin
                if (s_valid && (lane == LAST_LANE || s_last)) begin
                    push_req  = 1'b1;
                    push_word = word_next;
                    push_last = s_last;
                end
            end
            PK_FLUSH: begin
                push_req  = 1'b1;
                push_last = 1'b1;
            end
            default: ;
        endcase
    end

    assign pop       = m_tvalid && m_tready;
    assign push_room = !fifo_full || pop;
    assign push      = push_req && push_room;

    sync_fifo_fwft #(
        .WIDTH (DRAM_WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .push      (push),
        .push_data ({push_last, push_word}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_head[DRAM_WORD_W-1:0];
    assign m_tlast  = fifo_head[DRAM_WORD_W];

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state          <= PK_RUN;
            lane           <= '0;
            pack_reg       <= '0;
            pix_cnt        <= '0;
            frame_error    <= 1'b0;
            overflow       <= 1'b0;
            frames_dropped <= '0;
        end else begin
            frame_error <= 1'b0;
            // Counted in every state so pixels dropped in FLUSH still belong to the next frame.
            if (s_valid) begin
                if (s_last) begin
                    frame_error <= (pix_cnt + 20'd1 != 20'(FRAME_PIXELS));
                    pix_cnt     <= '0;
                end else begin
                    pix_cnt <= pix_cnt + 20'd1;
                end
            end

            case (state)
                PK_RUN: begin
                    if (s_valid) begin
                        if (push_req) begin
                            lane     <= '0;
                            pack_reg <= '0;
                            if (!push_room) begin
                                overflow <= 1'b1;
                                if (frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
                                state <= s_last ? PK_FLUSH : PK_DISCARD;
                            end
                        end else begin
                            lane     <= lane + LANE_W'(1);
                            pack_reg <= word_next;
                        end
                    end
                end
                PK_DISCARD: begin
                    if (s_valid && s_last) state <= PK_FLUSH;
                end
                PK_FLUSH: begin
                    if (push_room) state <= PK_RUN;
                end
                default: state <= PK_RUN;
            endcase
        end
    end
endmodule
